// File: rtl/reg_file_pkg.sv
// Shared widths, constants and read-source selection for the MIPS32 register file.
package reg_file_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_NUM        = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = '0;
  localparam logic [WORD_WIDTH-1:0]     ZERO_WORD = '0;

  typedef struct packed {
    logic hi;
    logic lo;
  } hilo_we_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_ARRAY
  } rd_src_t;

  // Reset forces zero on every read port, and $zero wins over a bypass hit.
  function automatic rd_src_t read_source(input logic in_reset,
                                          input logic is_zero,
                                          input logic bypass_hit);
    if (in_reset || is_zero) return SRC_ZERO;
    if (bypass_hit)          return SRC_BYPASS;
    return SRC_ARRAY;
  endfunction

endpackage

// File: rtl/reg_file_hilo.sv
// HI/LO register pair with independent write strobes and optional write-through.
module hilo_reg
  import reg_file_pkg::*;
#(
  parameter int unsigned W      = WORD_WIDTH,
  parameter bit          BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   hilo_we,
  input  logic [W-1:0] hi_wdata,
  input  logic [W-1:0] lo_wdata,
  output logic [W-1:0] hi_rdata,
  output logic [W-1:0] lo_rdata
);

  hilo_we_t     we;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  rd_src_t      hi_src;
  rd_src_t      lo_src;

  assign we = hilo_we_t'(hilo_we);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (we.hi) hi_q <= hi_wdata;
      if (we.lo) lo_q <= lo_wdata;
    end
  end

  always_comb begin
    hi_src   = read_source(!rst, 1'b0, BYPASS && we.hi);
    hi_rdata = '0;
    unique case (hi_src)
      SRC_BYPASS: hi_rdata = hi_wdata;
      SRC_ARRAY:  hi_rdata = hi_q;
      default:    hi_rdata = '0;
    endcase
  end

  always_comb begin
    lo_src   = read_source(!rst, 1'b0, BYPASS && we.lo);
    lo_rdata = '0;
    unique case (lo_src)
      SRC_BYPASS: lo_rdata = lo_wdata;
      SRC_ARRAY:  lo_rdata = lo_q;
      default:    lo_rdata = '0;
    endcase
  end

  hilo_we_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(hilo_we));

endmodule

// File: rtl/reg_file.sv
// MIPS32 architectural register file: 32 GPRs with write-through reads, plus HI/LO.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned W      = WORD_WIDTH,
  parameter int unsigned AW     = REG_ADDR_WIDTH,
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_en,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  reg_write_data,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2,
  input  logic [1:0]    hilo_we,
  input  logic [W-1:0]  hi_wdata,
  input  logic [W-1:0]  lo_wdata,
  output logic [W-1:0]  hi_rdata,
  output logic [W-1:0]  lo_rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0] gpr [DEPTH];
  rd_src_t      src1;
  rd_src_t      src2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) gpr[i] <= '0;
    end else if (write_en && waddr != '0) begin
      gpr[waddr] <= reg_write_data;
    end
  end

  always_comb begin
    src1   = read_source(!rst, raddr1 == '0, BYPASS && write_en && (waddr == raddr1));
    rdata1 = '0;
    unique case (src1)
      SRC_BYPASS: rdata1 = reg_write_data;
      SRC_ARRAY:  rdata1 = gpr[raddr1];
      default:    rdata1 = '0;
    endcase
  end

  always_comb begin
    src2   = read_source(!rst, raddr2 == '0, BYPASS && write_en && (waddr == raddr2));
    rdata2 = '0;
    unique case (src2)
      SRC_BYPASS: rdata2 = reg_write_data;
      SRC_ARRAY:  rdata2 = gpr[raddr2];
      default:    rdata2 = '0;
    endcase
  end

  // Stored array only; the peek port never sees an in-flight write.
  assign dbg_data = gpr[dbg_addr];

  hilo_reg #(
    .W      (W),
    .BYPASS (BYPASS)
  ) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

  write_en_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(write_en));

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one write-through instance and one BYPASS=0 instance on shared inputs.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
  logic [31:0] reg_write_data, hi_wdata, lo_wdata;
  logic [1:0]  hilo_we;
  logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata, dbg_data;
  logic [31:0] rdata1_nb, rdata2_nb, hi_rdata_nb, lo_rdata_nb, dbg_data_nb;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef enum int {O_RD1, O_RD2, O_HI, O_LO, O_DBG, N_RD1, N_RD2, N_HI, N_LO, N_DBG} obs_t;

  typedef struct {
    string       tag;
    obs_t        sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  always #5 clk = ~clk;

  reg_file #(.W(32), .AW(5), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .write_en(write_en), .waddr(waddr),
    .reg_write_data(reg_write_data), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_rdata(hi_rdata),
    .lo_rdata(lo_rdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file #(.W(32), .AW(5), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .write_en(write_en), .waddr(waddr),
    .reg_write_data(reg_write_data), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1_nb), .rdata2(rdata2_nb), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_rdata(hi_rdata_nb),
    .lo_rdata(lo_rdata_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input obs_t s);
    case (s)
      O_RD1:   return rdata1;
      O_RD2:   return rdata2;
      O_HI:    return hi_rdata;
      O_LO:    return lo_rdata;
      O_DBG:   return dbg_data;
      N_RD1:   return rdata1_nb;
      N_RD2:   return rdata2_nb;
      N_HI:    return hi_rdata_nb;
      N_LO:    return lo_rdata_nb;
      default: return dbg_data_nb;
    endcase
  endfunction

  task automatic expect_out(input string tag, input obs_t s, input logic [31:0] exp);
    sb.push_back('{tag, s, exp});
  endtask

  task automatic settle_and_check();
    sb_item_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int unsigned i);
    logic [31:0] v;
    v = 32'(i) * 32'h0101_0101;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; write_en = 1'b0; waddr = '0; reg_write_data = '0;
    raddr1 = '0; raddr2 = '0; dbg_addr = '0;
    hilo_we = '0; hi_wdata = '0; lo_wdata = '0;
    tick();

    // reset: outputs zero, and an asserted write must neither bypass nor land
    write_en = 1'b1; waddr = 5'd5; reg_write_data = 32'hDEAD_BEEF; raddr1 = 5'd5;
    hilo_we = 2'b11; hi_wdata = 32'h1111_1111; lo_wdata = 32'h2222_2222;
    expect_out("rst_rd1", O_RD1, 32'h0);
    expect_out("rst_hi", O_HI, 32'h0);
    expect_out("rst_lo", O_LO, 32'h0);
    settle_and_check();
    tick();
    write_en = 1'b0; hilo_we = 2'b00;
    expect_out("rst_dbg_noland", O_DBG, 32'h0);
    settle_and_check();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // test 1: write r5, then reset mid-cycle
    write_en = 1'b1; waddr = 5'd5; reg_write_data = 32'hDEAD_BEEF; raddr1 = 5'd5; dbg_addr = 5'd5;
    expect_out("t1_bypass", O_RD1, 32'hDEAD_BEEF);
    expect_out("t1_nb_old", N_RD1, 32'h0);
    settle_and_check();
    tick();
    write_en = 1'b0;
    expect_out("t1_stored", O_RD1, 32'hDEAD_BEEF);
    expect_out("t1_nb_stored", N_RD1, 32'hDEAD_BEEF);
    settle_and_check();
    #1 rst = 1'b0;
    expect_out("t1_rst_rd1", O_RD1, 32'h0);
    expect_out("t1_rst_nb_rd1", N_RD1, 32'h0);
    expect_out("t1_rst_dbg", O_DBG, 32'h0);
    settle_and_check();
    @(negedge clk);
    rst = 1'b1;
    tick();
    expect_out("t1_after_rel", O_RD1, 32'h0);
    settle_and_check();

    // test 2: $zero never written, never bypassed
    write_en = 1'b1; waddr = 5'd0; reg_write_data = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    expect_out("t2_rd1", O_RD1, 32'h0);
    expect_out("t2_rd2", O_RD2, 32'h0);
    expect_out("t2_nb_rd1", N_RD1, 32'h0);
    settle_and_check();
    tick();
    write_en = 1'b0; dbg_addr = 5'd0;
    expect_out("t2_rd1_later", O_RD1, 32'h0);
    expect_out("t2_dbg0", O_DBG, 32'h0);
    settle_and_check();

    // test 3: both ports hit the bypass together
    write_en = 1'b1; waddr = 5'd7; reg_write_data = 32'h1234_5678; raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7;
    expect_out("t3_rd1", O_RD1, 32'h1234_5678);
    expect_out("t3_rd2", O_RD2, 32'h1234_5678);
    expect_out("t3_nb_rd1", N_RD1, 32'h0);
    expect_out("t3_nb_rd2", N_RD2, 32'h0);
    expect_out("t3_dbg_nobyp", O_DBG, 32'h0);
    settle_and_check();
    tick();
    write_en = 1'b0;
    expect_out("t3_nb_rd1_next", N_RD1, 32'h1234_5678);
    expect_out("t3_nb_rd2_next", N_RD2, 32'h1234_5678);
    settle_and_check();

    // test 4: back-to-back writes
    write_en = 1'b1; waddr = 5'd3; reg_write_data = 32'h1;
    tick();
    reg_write_data = 32'h2;
    tick();
    waddr = 5'd4; reg_write_data = 32'h3;
    tick();
    write_en = 1'b0; raddr1 = 5'd3; raddr2 = 5'd4;
    expect_out("t4_r3", O_RD1, 32'h2);
    expect_out("t4_r4", O_RD2, 32'h3);
    settle_and_check();
    dbg_addr = 5'd2;
    expect_out("t4_r2_clean", O_DBG, 32'h0);
    settle_and_check();
    dbg_addr = 5'd5;
    expect_out("t4_r5_clean", O_DBG, 32'h0);
    settle_and_check();

    // test 5: HI then LO, plus a GPR write alongside the LO write
    hilo_we = 2'b10; hi_wdata = 32'hAAAA_0000; lo_wdata = 32'hFFFF_0000;
    expect_out("t5_hi_byp", O_HI, 32'hAAAA_0000);
    expect_out("t5_lo_nowe", O_LO, 32'h0);
    expect_out("t5_nb_hi_old", N_HI, 32'h0);
    settle_and_check();
    tick();
    hilo_we = 2'b01; hi_wdata = 32'h1234_5678; lo_wdata = 32'h0000_5555;
    write_en = 1'b1; waddr = 5'd9; reg_write_data = 32'h99; raddr1 = 5'd9;
    expect_out("t5_hi_kept", O_HI, 32'hAAAA_0000);
    expect_out("t5_lo_byp", O_LO, 32'h0000_5555);
    expect_out("t5_nb_hi", N_HI, 32'hAAAA_0000);
    expect_out("t5_nb_lo_old", N_LO, 32'h0);
    expect_out("t5_gpr_byp", O_RD1, 32'h99);
    settle_and_check();
    tick();
    hilo_we = 2'b00; write_en = 1'b0;
    expect_out("t5_hi", O_HI, 32'hAAAA_0000);
    expect_out("t5_lo", O_LO, 32'h0000_5555);
    expect_out("t5_nb_lo", N_LO, 32'h0000_5555);
    expect_out("t5_gpr_r9", N_RD1, 32'h99);
    settle_and_check();

    // test 6: sweep all GPRs, then an attempted write to r0
    for (int unsigned i = 1; i < 32; i++) begin
      write_en = 1'b1; waddr = 5'(i); reg_write_data = sweep_val(i);
      tick();
    end
    waddr = 5'd0; reg_write_data = 32'hFFFF_FFFF;
    tick();
    write_en = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); raddr1 = 5'(i); raddr2 = 5'(31 - i);
      expect_out($sformatf("t6_dbg_r%0d", i), O_DBG, sweep_val(i));
      expect_out($sformatf("t6_nb_dbg_r%0d", i), N_DBG, sweep_val(i));
      expect_out($sformatf("t6_rd1_r%0d", i), O_RD1, sweep_val(i));
      expect_out($sformatf("t6_rd2_r%0d", 31 - i), O_RD2, sweep_val(31 - i));
      settle_and_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
